// File: rtl/mlp_layer_seq.sv
// Control sequencer for a two-layer MLP: P-lane layer-1 MAC rounds, activation via LUT,
// layer-2 accumulate into output SRAM, then output activation. Optional: MLP_LAYER_SEQ_STALL_EN.
module mlp_layer_seq #(
    parameter int unsigned N_IN  = 784,
    parameter int unsigned N_HID = 200,
    parameter int unsigned P     = 10,
    parameter int unsigned N_OUT = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
`ifdef MLP_LAYER_SEQ_STALL_EN
    input  logic                     stall,
`endif
    output logic                     busy,
    output logic                     done,
    output logic                     mac_en,
    output logic                     mac_clear,
    output logic [$clog2(N_IN)-1:0]  in_addr,
    output logic                     hold_we,
    output logic                     hold_sel,
    output logic [$clog2(P)-1:0]     hold_addr,
    output logic                     lut_sel,
    output logic [$clog2(N_HID)-1:0] w2_hid_addr,
    output logic [$clog2(N_OUT)-1:0] w2_out_addr,
    output logic [$clog2(N_OUT)-1:0] acc_addr,
    output logic                     acc_we,
    output logic                     acc_sel,
    output logic                     acc_clr
);

    localparam int unsigned IW = $clog2(N_IN);
    localparam int unsigned PW = $clog2(P);
    localparam int unsigned HW = $clog2(N_HID);
    localparam int unsigned OW = $clog2(N_OUT);
    localparam int unsigned R  = N_HID / P;
    localparam int unsigned RW = (R > 1) ? $clog2(R) : 1;

    localparam logic [IW-1:0] ILast = IW'(N_IN - 1);
    localparam logic [PW-1:0] JLast = PW'(P - 1);
    localparam logic [OW-1:0] KLast = OW'(N_OUT - 1);
    localparam logic [RW-1:0] RLast = RW'(R - 1);

    typedef enum logic [3:0] {
        StIdle, StL1Acc, StL1Cap, StActRd, StActWr, StL2Mac, StOutRd, StOutWr, StDone
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   i_q, i_d;
    logic [PW-1:0]   j_q, j_d;
    logic [OW-1:0]   k_q, k_d;
    logic [RW-1:0]   r_q, r_d;
    logic            frz;

`ifdef MLP_LAYER_SEQ_STALL_EN
    assign frz = stall;
`else
    assign frz = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            r_q     <= r_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        j_d         = j_q;
        k_d         = k_q;
        r_d         = r_q;
        busy        = 1'b1;
        done        = 1'b0;
        mac_en      = 1'b0;
        mac_clear   = 1'b0;
        in_addr     = '0;
        hold_we     = 1'b0;
        hold_sel    = 1'b0;
        hold_addr   = '0;
        lut_sel     = 1'b0;
        w2_hid_addr = '0;
        w2_out_addr = '0;
        acc_addr    = '0;
        acc_we      = 1'b0;
        acc_sel     = 1'b0;
        acc_clr     = 1'b0;

        case (state_q)
            StIdle: begin
                busy = 1'b0;
                i_d  = '0;
                j_d  = '0;
                k_d  = '0;
                r_d  = '0;
                if (start) state_d = StL1Acc;
            end
            StL1Acc: begin
                mac_en    = 1'b1;
                mac_clear = (i_q == '0);
                in_addr   = i_q;
                if (i_q == ILast) begin
                    i_d     = '0;
                    state_d = StL1Cap;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            StL1Cap: begin
                hold_we = 1'b1;
                j_d     = '0;
                state_d = StActRd;
            end
            StActRd: begin
                hold_addr = j_q;
                state_d   = StActWr;
            end
            StActWr: begin
                hold_we   = 1'b1;
                hold_sel  = 1'b1;
                hold_addr = j_q;
                if (j_q == JLast) begin
                    j_d     = '0;
                    k_d     = '0;
                    state_d = StL2Mac;
                end else begin
                    j_d     = j_q + 1'b1;
                    state_d = StActRd;
                end
            end
            StL2Mac: begin
                hold_addr   = j_q;
                acc_addr    = k_q;
                w2_hid_addr = HW'(32'(r_q) * P + 32'(j_q));
                w2_out_addr = k_q;
                acc_we      = 1'b1;
                // First hidden neuron of the first round seeds the output accumulators.
                acc_clr     = (r_q == '0) && (j_q == '0);
                if (k_q == KLast) begin
                    k_d = '0;
                    if (j_q == JLast) begin
                        j_d = '0;
                        if (r_q == RLast) begin
                            state_d = StOutRd;
                        end else begin
                            r_d     = r_q + 1'b1;
                            state_d = StL1Acc;
                        end
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            StOutRd: begin
                acc_addr = k_q;
                lut_sel  = 1'b1;
                state_d  = StOutWr;
            end
            StOutWr: begin
                acc_addr = k_q;
                acc_we   = 1'b1;
                acc_sel  = 1'b1;
                if (k_q == KLast) begin
                    k_d     = '0;
                    state_d = StDone;
                end else begin
                    k_d     = k_q + 1'b1;
                    state_d = StOutRd;
                end
            end
            StDone: begin
                done    = 1'b1;
                r_d     = '0;
                state_d = StIdle;
            end
            default: begin
                busy    = 1'b0;
                state_d = StIdle;
            end
        endcase

        // Stall freezes progress; addresses stay put because state and counters hold.
        if (frz) begin
            state_d = state_q;
            i_d     = i_q;
            j_d     = j_q;
            k_d     = k_q;
            r_d     = r_q;
            mac_en  = 1'b0;
            hold_we = 1'b0;
            acc_we  = 1'b0;
        end
    end

endmodule

// File: tb/tb_mlp_layer_seq.sv
// Self-checking bench for mlp_layer_seq (N_IN=4, N_HID=4, P=2, N_OUT=3): schedule model,
// spot-vector table, random start noise and resets, back-to-back starts, optional stall.
module tb_mlp_layer_seq;

    localparam int N_IN  = 4;
    localparam int N_HID = 4;
    localparam int P     = 2;
    localparam int N_OUT = 3;
    localparam int R     = N_HID / P;
    localparam int LAT   = R * (N_IN + 1 + 2 * P + P * N_OUT) + 2 * N_OUT + 1;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       mac_en;
        logic       mac_clear;
        logic [1:0] in_addr;
        logic       hold_we;
        logic       hold_sel;
        logic [0:0] hold_addr;
        logic       lut_sel;
        logic [1:0] w2_hid_addr;
        logic [1:0] w2_out_addr;
        logic [1:0] acc_addr;
        logic       acc_we;
        logic       acc_sel;
        logic       acc_clr;
    } outs_t;

    typedef struct {
        int    cyc;
        outs_t exp;
    } spot_t;

    logic       clk;
    logic       reset;
    logic       start;
`ifdef MLP_LAYER_SEQ_STALL_EN
    logic       stall;
`endif
    logic       busy, done, mac_en, mac_clear, hold_we, hold_sel, lut_sel;
    logic       acc_we, acc_sel, acc_clr;
    logic [1:0] in_addr, w2_hid_addr, w2_out_addr, acc_addr;
    logic [0:0] hold_addr;

    int    n_vec = 0;
    int    n_bad = 0;
    outs_t exp_q[$];
    outs_t obs_log[0:80];
    spot_t tbl[16];

    mlp_layer_seq #(
        .N_IN (N_IN),
        .N_HID(N_HID),
        .P    (P),
        .N_OUT(N_OUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
`ifdef MLP_LAYER_SEQ_STALL_EN
        .stall      (stall),
`endif
        .busy       (busy),
        .done       (done),
        .mac_en     (mac_en),
        .mac_clear  (mac_clear),
        .in_addr    (in_addr),
        .hold_we    (hold_we),
        .hold_sel   (hold_sel),
        .hold_addr  (hold_addr),
        .lut_sel    (lut_sel),
        .w2_hid_addr(w2_hid_addr),
        .w2_out_addr(w2_out_addr),
        .acc_addr   (acc_addr),
        .acc_we     (acc_we),
        .acc_sel    (acc_sel),
        .acc_clr    (acc_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic outs_t sample();
        outs_t o;
        o.busy = busy; o.done = done; o.mac_en = mac_en; o.mac_clear = mac_clear;
        o.in_addr = in_addr; o.hold_we = hold_we; o.hold_sel = hold_sel;
        o.hold_addr = hold_addr; o.lut_sel = lut_sel; o.w2_hid_addr = w2_hid_addr;
        o.w2_out_addr = w2_out_addr; o.acc_addr = acc_addr; o.acc_we = acc_we;
        o.acc_sel = acc_sel; o.acc_clr = acc_clr;
        return o;
    endfunction

    function automatic outs_t mk(input bit b, input bit d, input bit me, input bit mc,
                                 input int ia, input bit hw, input bit hs, input int ha,
                                 input bit ls, input int wh, input int wo, input int aa,
                                 input bit aw, input bit as, input bit ac);
        outs_t o;
        o.busy = b; o.done = d; o.mac_en = me; o.mac_clear = mc; o.in_addr = 2'(ia);
        o.hold_we = hw; o.hold_sel = hs; o.hold_addr = 1'(ha); o.lut_sel = ls;
        o.w2_hid_addr = 2'(wh); o.w2_out_addr = 2'(wo); o.acc_addr = 2'(aa);
        o.acc_we = aw; o.acc_sel = as; o.acc_clr = ac;
        return o;
    endfunction

    // Per-cycle output schedule of one inference, derived from the phase description.
    task automatic build_model();
        outs_t o;
        exp_q.delete();
        for (int r = 0; r < R; r++) begin
            for (int i = 0; i < N_IN; i++) exp_q.push_back(mk(1,0,1,i==0,i,0,0,0,0,0,0,0,0,0,0));
            exp_q.push_back(mk(1,0,0,0,0,1,0,0,0,0,0,0,0,0,0));
            for (int j = 0; j < P; j++) begin
                exp_q.push_back(mk(1,0,0,0,0,0,0,j,0,0,0,0,0,0,0));
                exp_q.push_back(mk(1,0,0,0,0,1,1,j,0,0,0,0,0,0,0));
            end
            for (int j = 0; j < P; j++)
                for (int k = 0; k < N_OUT; k++)
                    exp_q.push_back(mk(1,0,0,0,0,0,0,j,0,r*P+j,k,k,1,0,(r==0)&&(j==0)));
        end
        for (int k = 0; k < N_OUT; k++) begin
            exp_q.push_back(mk(1,0,0,0,0,0,0,0,1,0,0,k,0,0,0));
            exp_q.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,k,1,1,0));
        end
        o = '0; o.busy = 1'b1; o.done = 1'b1;
        exp_q.push_back(o);
    endtask

    task automatic check(input string name, input int c, input outs_t got, input outs_t want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h want %h", name, c, got, want);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // One inference from IDLE; optional reset at cycle rst_at, 5-cycle stall from stall_at.
    task automatic run_one(input int rst_at, input int stall_at, input bit noise,
                           output int done_cyc);
        int    idx;
        bit    stl;
        outs_t e, g;
        done_cyc = 0;
        idx      = 0;
        start    = 1'b1;
        #1;
        check("idle_pre_accept", 0, sample(), '0);
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 80; c++) begin
            stl = (stall_at != 0) && (c >= stall_at) && (c < stall_at + 5);
`ifdef MLP_LAYER_SEQ_STALL_EN
            stall = stl;
`endif
            start = (noise && idx < exp_q.size()) ? 1'($urandom % 2) : 1'b0;
            reset = (c == rst_at);
            #1;
            e = (idx < exp_q.size()) ? exp_q[idx] : '0;
            if (stl) begin
                e.mac_en = 1'b0; e.hold_we = 1'b0; e.acc_we = 1'b0;
            end
            g = sample();
            obs_log[c] = g;
            check("seq", c, g, e);
            if (g.done) done_cyc = c;
            if (!stl) idx++;
            @(posedge clk); #1;
`ifdef MLP_LAYER_SEQ_STALL_EN
            stall = 1'b0;
`endif
            if (reset) begin
                reset = 1'b0;
                start = 1'b0;
                check("after_reset", c + 1, sample(), '0);
                return;
            end
            if (idx > exp_q.size()) return;
        end
        n_vec++;
        n_bad++;
        $display("FAIL run_timeout: got no return to idle want %0d cycles", LAT + 1);
    endtask

    initial begin
        int d, prev, ndone, cnt_clr, cnt_mclr, rst_at;
        outs_t e, g;
        reset = 1'b1;
        start = 1'b0;
`ifdef MLP_LAYER_SEQ_STALL_EN
        stall = 1'b0;
`endif
        build_model();

        tbl[0]  = '{1,  mk(1,0,1,1,0, 0,0,0,0, 0,0,0, 0,0,0)};
        tbl[1]  = '{2,  mk(1,0,1,0,1, 0,0,0,0, 0,0,0, 0,0,0)};
        tbl[2]  = '{4,  mk(1,0,1,0,3, 0,0,0,0, 0,0,0, 0,0,0)};
        tbl[3]  = '{5,  mk(1,0,0,0,0, 1,0,0,0, 0,0,0, 0,0,0)};
        tbl[4]  = '{8,  mk(1,0,0,0,0, 0,0,1,0, 0,0,0, 0,0,0)};
        tbl[5]  = '{9,  mk(1,0,0,0,0, 1,1,1,0, 0,0,0, 0,0,0)};
        tbl[6]  = '{10, mk(1,0,0,0,0, 0,0,0,0, 0,0,0, 1,0,1)};
        tbl[7]  = '{12, mk(1,0,0,0,0, 0,0,0,0, 0,2,2, 1,0,1)};
        tbl[8]  = '{13, mk(1,0,0,0,0, 0,0,1,0, 1,0,0, 1,0,0)};
        tbl[9]  = '{16, mk(1,0,1,1,0, 0,0,0,0, 0,0,0, 0,0,0)};
        tbl[10] = '{25, mk(1,0,0,0,0, 0,0,0,0, 2,0,0, 1,0,0)};
        tbl[11] = '{30, mk(1,0,0,0,0, 0,0,1,0, 3,2,2, 1,0,0)};
        tbl[12] = '{33, mk(1,0,0,0,0, 0,0,0,1, 0,0,1, 0,0,0)};
        tbl[13] = '{36, mk(1,0,0,0,0, 0,0,0,0, 0,0,2, 1,1,0)};
        tbl[14] = '{37, mk(1,1,0,0,0, 0,0,0,0, 0,0,0, 0,0,0)};
        tbl[15] = '{38, mk(0,0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0)};

        @(posedge clk); #1;
        @(posedge clk); #1;
        check("reset_state", 0, sample(), '0);
        reset = 1'b0;

        // Clean inference, then spot-check the hand-computed table and per-round pulses.
        run_one(0, 0, 1'b0, d);
        check_int("latency", d, LAT);
        for (int n = 0; n < 16; n++) check("spot", tbl[n].cyc, obs_log[tbl[n].cyc], tbl[n].exp);
        cnt_clr = 0;
        cnt_mclr = 0;
        for (int c = 1; c <= LAT; c++) begin
            cnt_clr  += int'(obs_log[c].acc_clr);
            cnt_mclr += int'(obs_log[c].mac_clear);
        end
        check_int("acc_clr_count", cnt_clr, N_OUT);
        check_int("mac_clear_count", cnt_mclr, R);

        // Reset during round-1 L2_MAC, then a fresh start must complete normally.
        run_one(27, 0, 1'b0, d);
        check_int("no_done_on_reset", d, 0);
        run_one(0, 0, 1'b0, d);
        check_int("latency_after_reset", d, LAT);

        // Random start noise while busy, random mid-run resets, random idle gaps.
        for (int it = 0; it < 20; it++) begin
            for (int g2 = 0; g2 < int'($urandom_range(0, 2)); g2++) begin
                @(posedge clk); #1;
                check("idle_gap", 0, sample(), '0);
            end
            rst_at = ($urandom % 3 == 0) ? int'($urandom_range(1, LAT)) : 0;
            run_one(rst_at, 0, 1'($urandom % 2), d);
            if (rst_at == 0) check_int("latency_rand", d, LAT);
        end

        // start held high: one inference every LAT+1 cycles.
        start = 1'b1;
        prev  = 0;
        ndone = 0;
        @(posedge clk); #1;
        for (int c = 1; c <= 3 * (LAT + 1); c++) begin
            e = (((c - 1) % (LAT + 1)) < LAT) ? exp_q[(c - 1) % (LAT + 1)] : '0;
            g = sample();
            check("b2b", c, g, e);
            if (g.done) begin
                check_int("done_period", c - prev, (prev == 0) ? LAT : LAT + 1);
                prev = c;
                ndone++;
            end
            if (c == 3 * (LAT + 1)) start = 1'b0;
            @(posedge clk); #1;
        end
        check_int("b2b_done_count", ndone, 3);
        check("b2b_idle", 0, sample(), '0);

`ifdef MLP_LAYER_SEQ_STALL_EN
        run_one(0, 2, 1'b0, d);
        check_int("latency_stall", d, LAT + 5);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
